// File: rtl/exmu_sequencer.sv
// exmu_sequencer: control sequencer for the Extension Memory Unit (ExMU).
// Takes extension read/write/flush requests, checks the ExMU hit flags,
// drives the cache and point strobes, and runs the line fill and write-back
// handshakes with the memory interface. This is a Moore FSM: every output is
// decoded from registered state only.
// Optional feature: define EXMU_SEQ_PERF_EN to add saturating hit/miss
// counters (o_perfHits / o_perfMisses).
module exmu_sequencer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_SYSTEM_clk,
  input  logic        i_SYSTEM_rst,
  input  logic        i_EXT_readReq,
  input  logic        i_EXT_writeReq,
  input  logic        i_EXT_flushReq,
  output logic        o_EXT_readAck,
  output logic        o_EXT_writeAck,
  output logic        o_EXT_flushAck,
  input  logic        i_ExMU_readInCache,
  input  logic        i_ExMU_writeInCache,
  output logic        o_CU_ExMU_readCache,
  output logic        o_CU_ExMU_writeCache,
  output logic        o_CU_ExMU_readPoint,
  output logic        o_CU_ExMU_writePoint,
  output logic        o_CU_ExMU_writeMem,
  output logic        o_CU_ExMU_readWriteID,
  output logic        o_MEM_readReq,
  input  logic        i_MEM_readValid,
  output logic        o_MEM_writeReq,
  input  logic        i_MEM_writeDone,
  output logic        o_busy,
  output logic        o_error,
`ifdef EXMU_SEQ_PERF_EN
  output logic [31:0] o_perfHits,
  output logic [31:0] o_perfMisses,
`endif
  output logic [3:0]  o_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SET_ID = 4'd1,
    MEM_RD = 4'd2,
    FILL_R = 4'd3,
    FILL_W = 4'd4,
    RD_PT  = 4'd5,
    RD_ACK = 4'd6,
    WR_PT  = 4'd7,
    WR_ACK = 4'd8,
    WB_LD  = 4'd9,
    MEM_WR = 4'd10,
    FL_ACK = 4'd11
  } state_t;

  // Pending operation, remembered so shared states (SET_ID, MEM_RD, MEM_WR)
  // know where to go next and which ack to give on a timeout.
  typedef enum logic [1:0] {
    OP_RD = 2'd0,
    OP_WR = 2'd1,
    OP_FL = 2'd2
  } op_t;

  state_t      state, next_state;
  op_t         op, next_op;
  logic        dirty;
  logic        clr_dirty;
  logic        set_error;
  logic        take_hit;
  logic        take_miss;
  logic [15:0] tmo_count;
  logic        timed_out;
  logic        in_mem_state;

  assign in_mem_state = (state == MEM_RD) || (state == MEM_WR);
  assign timed_out    = (tmo_count == 16'(TIMEOUT - 1));
  assign o_state      = state;

  // Next-state logic: request arbitration in IDLE, handshake exits and timeouts.
  always_comb begin
    next_state = state;
    next_op    = op;
    clr_dirty  = 1'b0;
    set_error  = 1'b0;
    take_hit   = 1'b0;
    take_miss  = 1'b0;
    case (state)
      IDLE: begin
        if (i_EXT_flushReq) begin
          next_op    = OP_FL;
          next_state = dirty ? WB_LD : FL_ACK;
        end else if (i_EXT_writeReq) begin
          next_op = OP_WR;
          if (i_ExMU_writeInCache) begin
            take_hit   = 1'b1;
            next_state = WR_PT;
          end else begin
            take_miss  = 1'b1;
            next_state = dirty ? WB_LD : SET_ID;
          end
        end else if (i_EXT_readReq) begin
          next_op = OP_RD;
          if (i_ExMU_readInCache) begin
            take_hit   = 1'b1;
            next_state = RD_PT;
          end else begin
            take_miss  = 1'b1;
            next_state = SET_ID;
          end
        end
      end
      SET_ID: next_state = MEM_RD;
      MEM_RD: begin
        if (i_MEM_readValid) begin
          next_state = (op == OP_WR) ? FILL_W : FILL_R;
        end else if (timed_out) begin
          set_error  = 1'b1;
          next_state = (op == OP_WR) ? WR_ACK : RD_ACK;
        end
      end
      FILL_R: next_state = RD_PT;
      FILL_W: next_state = WR_PT;
      RD_PT:  next_state = RD_ACK;
      WR_PT:  next_state = WR_ACK;
      WB_LD:  next_state = MEM_WR;
      MEM_WR: begin
        if (i_MEM_writeDone) begin
          clr_dirty  = 1'b1;
          next_state = (op == OP_FL) ? FL_ACK : SET_ID;
        end else if (timed_out) begin
          set_error  = 1'b1;
          next_state = (op == OP_FL) ? FL_ACK : WR_ACK;
        end
      end
      RD_ACK, WR_ACK, FL_ACK: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, pending op, dirty flag, sticky error and handshake timeout counter.
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      state     <= IDLE;
      op        <= OP_RD;
      dirty     <= 1'b0;
      o_error   <= 1'b0;
      tmo_count <= 16'd0;
    end else begin
      state <= next_state;
      op    <= next_op;
      if (clr_dirty) begin
        dirty <= 1'b0;
      end else if (state == WR_PT) begin
        dirty <= 1'b1;
      end
      if (set_error) begin
        o_error <= 1'b1;
      end
      if (in_mem_state && (next_state == state)) begin
        tmo_count <= tmo_count + 16'd1;
      end else begin
        tmo_count <= 16'd0;
      end
    end
  end

  // Output decode from the registered state (and registered pending op).
  always_comb begin
    o_EXT_readAck         = 1'b0;
    o_EXT_writeAck        = 1'b0;
    o_EXT_flushAck        = 1'b0;
    o_CU_ExMU_readCache   = 1'b0;
    o_CU_ExMU_writeCache  = 1'b0;
    o_CU_ExMU_readPoint   = 1'b0;
    o_CU_ExMU_writePoint  = 1'b0;
    o_CU_ExMU_writeMem    = 1'b0;
    o_CU_ExMU_readWriteID = 1'b0;
    o_MEM_readReq         = 1'b0;
    o_MEM_writeReq        = 1'b0;
    o_busy                = (state != IDLE);
    case (state)
      SET_ID: o_CU_ExMU_readWriteID = (op == OP_WR);
      MEM_RD: begin
        o_MEM_readReq         = 1'b1;
        o_CU_ExMU_readWriteID = (op == OP_WR);
      end
      FILL_R: o_CU_ExMU_readCache = 1'b1;
      FILL_W: begin
        o_CU_ExMU_writeCache  = 1'b1;
        o_CU_ExMU_readWriteID = (op == OP_WR);
      end
      RD_PT:  o_CU_ExMU_readPoint  = 1'b1;
      RD_ACK: o_EXT_readAck        = 1'b1;
      WR_PT:  o_CU_ExMU_writePoint = 1'b1;
      WR_ACK: o_EXT_writeAck       = 1'b1;
      WB_LD:  o_CU_ExMU_writeMem   = 1'b1;
      MEM_WR: o_MEM_writeReq       = 1'b1;
      FL_ACK: o_EXT_flushAck       = 1'b1;
      default: ;
    endcase
  end

`ifdef EXMU_SEQ_PERF_EN
  // Saturating counters of read/write hit and miss decisions taken in IDLE.
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      o_perfHits   <= 32'd0;
      o_perfMisses <= 32'd0;
    end else begin
      if (take_hit && (o_perfHits != 32'hFFFF_FFFF)) begin
        o_perfHits <= o_perfHits + 32'd1;
      end
      if (take_miss && (o_perfMisses != 32'hFFFF_FFFF)) begin
        o_perfMisses <= o_perfMisses + 32'd1;
      end
    end
  end
`endif

endmodule
